// File: rtl/bomberman_pkg.sv
// Shared encodings and grid geometry for the bomb engine: cell codes, game
// outcome codes, wall coordinates and the bomb slot state enumeration.
package bomberman_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_ARMED = 2'd1,
        SLOT_BLAST = 2'd2
    } slotState_e;

    localparam logic [1:0] CELL_EMPTY  = 2'd0;
    localparam logic [1:0] CELL_BOMB_A = 2'd1;
    localparam logic [1:0] CELL_BOMB_B = 2'd2;
    localparam logic [1:0] CELL_BLAST  = 2'd3;

    localparam logic [1:0] GAME_RUNNING = 2'd0;
    localparam logic [1:0] GAME_A_WINS  = 2'd1;
    localparam logic [1:0] GAME_B_WINS  = 2'd2;
    localparam logic [1:0] GAME_DRAW    = 2'd3;

    localparam logic [3:0] GRID_MIN = 4'd0;
    localparam logic [3:0] GRID_MAX = 4'd9;

    // Plus-shaped footprint around (bx,by); wall cells never count as hit.
    function automatic logic inFootprint(input logic [3:0] bx, input logic [3:0] by,
                                         input logic [3:0] cx, input logic [3:0] cy);
        logic onWall;
        logic sameCol;
        logic sameRow;
        onWall  = (cx == GRID_MIN) || (cx >= GRID_MAX) || (cy == GRID_MIN) || (cy >= GRID_MAX);
        sameCol = (cx == bx) && ((cy == by) || (cy == by + 4'd1) || (cy == by - 4'd1));
        sameRow = (cy == by) && ((cx == bx + 4'd1) || (cx == bx - 4'd1));
        return !onWall && (sameCol || sameRow);
    endfunction

    function automatic logic [1:0] gameFromHealth(input logic [1:0] hA, input logic [1:0] hB);
        if (hA == 2'd0 && hB == 2'd0) return GAME_DRAW;
        if (hB == 2'd0)               return GAME_A_WINS;
        if (hA == 2'd0)               return GAME_B_WINS;
        return GAME_RUNNING;
    endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: IDLE/ARMED/BLAST state machine, fuse counter and the
// footprint tests against both players and the display query cell.
module bomb_slot
    import bomberman_pkg::*;
#(
    parameter int FUSE_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] loadX,
    input  logic [3:0] loadY,
    input  logic [3:0] playerAx,
    input  logic [3:0] playerAy,
    input  logic [3:0] playerBx,
    input  logic [3:0] playerBy,
    input  logic [3:0] rdX,
    input  logic [3:0] rdY,
    output slotState_e state,
    output logic [3:0] posX,
    output logic [3:0] posY,
    output logic       hitA,
    output logic       hitB,
    output logic       queryBlast,
    output logic       queryArmed
);

    slotState_e stateNext;
    logic [3:0] fuse;
    logic [3:0] fuseNext;
    logic [3:0] xNext;
    logic [3:0] yNext;
    logic       blastStart;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SLOT_IDLE;
            fuse  <= 4'd0;
            posX  <= 4'd0;
            posY  <= 4'd0;
        end else begin
            state <= stateNext;
            fuse  <= fuseNext;
            posX  <= xNext;
            posY  <= yNext;
        end
    end

    // run low (game decided) freezes the slot exactly where it is.
    always_comb begin
        stateNext  = state;
        fuseNext   = fuse;
        xNext      = posX;
        yNext      = posY;
        blastStart = 1'b0;
        if (run) begin
            case (state)
                SLOT_IDLE: begin
                    if (load) begin
                        stateNext = SLOT_ARMED;
                        fuseNext  = 4'(FUSE_TICKS);
                        xNext     = loadX;
                        yNext     = loadY;
                    end
                end
                SLOT_ARMED: begin
                    if (tick) begin
                        if (fuse <= 4'd1) begin
                            stateNext  = SLOT_BLAST;
                            fuseNext   = 4'd0;
                            blastStart = 1'b1;
                        end else begin
                            fuseNext = fuse - 4'd1;
                        end
                    end
                end
                SLOT_BLAST: begin
                    if (tick) stateNext = SLOT_IDLE;
                end
                default: stateNext = SLOT_IDLE;
            endcase
        end
    end

    assign hitA       = blastStart && inFootprint(posX, posY, playerAx, playerAy);
    assign hitB       = blastStart && inFootprint(posX, posY, playerBx, playerBy);
    assign queryBlast = (state == SLOT_BLAST) && inFootprint(posX, posY, rdX, rdY);
    assign queryArmed = (state == SLOT_ARMED) && (posX == rdX) && (posY == rdY);

endmodule

// File: rtl/bomb_engine.sv
// Two-player bomb engine: placement arbitration, health bookkeeping, game
// outcome and the display cell query over the two bomb slots.
module bomb_engine
    import bomberman_pkg::*;
#(
    parameter int FUSE_TICKS  = 3,
    parameter int HEALTH_INIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bomb_tick,
    input  logic       place_valid,
    input  logic       place_player,
    input  logic [3:0] place_x,
    input  logic [3:0] place_y,
    input  logic [3:0] playerAx,
    input  logic [3:0] playerAy,
    input  logic [3:0] playerBx,
    input  logic [3:0] playerBy,
    input  logic [3:0] rd_x,
    input  logic [3:0] rd_y,
    output logic       place_ack,
    output logic [1:0] rd_cell,
    output logic [1:0] healthA,
    output logic [1:0] healthB,
    output logic [1:0] game_state
);

    slotState_e st0, st1;
    logic [3:0] x0, y0, x1, y1;
    logic       hitA0, hitB0, hitA1, hitB1;
    logic       qBlast0, qArmed0, qBlast1, qArmed1;
    logic       running, inGrid, ownerIdle, otherArmedHere, accept;

    // Handshake: place_valid is a one-cycle request with no backpressure.
    // place_ack pulses on the cycle after an accepted request (the cycle the
    // slot first reads ARMED); a rejected request is simply dropped.
    assign running        = (game_state == GAME_RUNNING);
    assign inGrid         = (place_x > GRID_MIN) && (place_x < GRID_MAX) &&
                            (place_y > GRID_MIN) && (place_y < GRID_MAX);
    assign ownerIdle      = place_player ? (st1 == SLOT_IDLE) : (st0 == SLOT_IDLE);
    assign otherArmedHere = place_player
                          ? ((st0 == SLOT_ARMED) && (x0 == place_x) && (y0 == place_y))
                          : ((st1 == SLOT_ARMED) && (x1 == place_x) && (y1 == place_y));
    assign accept         = place_valid && running && ownerIdle && inGrid && !otherArmedHere;

    bomb_slot #(.FUSE_TICKS(FUSE_TICKS)) slotA (
        .clk(clk), .rst(rst), .run(running), .tick(bomb_tick),
        .load(accept && !place_player), .loadX(place_x), .loadY(place_y),
        .playerAx(playerAx), .playerAy(playerAy), .playerBx(playerBx), .playerBy(playerBy),
        .rdX(rd_x), .rdY(rd_y),
        .state(st0), .posX(x0), .posY(y0), .hitA(hitA0), .hitB(hitB0),
        .queryBlast(qBlast0), .queryArmed(qArmed0)
    );

    bomb_slot #(.FUSE_TICKS(FUSE_TICKS)) slotB (
        .clk(clk), .rst(rst), .run(running), .tick(bomb_tick),
        .load(accept && place_player), .loadX(place_x), .loadY(place_y),
        .playerAx(playerAx), .playerAy(playerAy), .playerBx(playerBx), .playerBy(playerBy),
        .rdX(rd_x), .rdY(rd_y),
        .state(st1), .posX(x1), .posY(y1), .hitA(hitA1), .hitB(hitB1),
        .queryBlast(qBlast1), .queryArmed(qArmed1)
    );

    // Simultaneous blasts OR together so a player loses at most one point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            healthA    <= 2'(HEALTH_INIT);
            healthB    <= 2'(HEALTH_INIT);
            game_state <= GAME_RUNNING;
            place_ack  <= 1'b0;
        end else begin
            place_ack <= accept;
            if ((hitA0 || hitA1) && healthA != 2'd0) healthA <= healthA - 2'd1;
            if ((hitB0 || hitB1) && healthB != 2'd0) healthB <= healthB - 2'd1;
            if (running) game_state <= gameFromHealth(healthA, healthB);
        end
    end

    always_comb begin
        rd_cell = CELL_EMPTY;
        if (qBlast0 || qBlast1) rd_cell = CELL_BLAST;
        else if (qArmed0)       rd_cell = CELL_BOMB_A;
        else if (qArmed1)       rd_cell = CELL_BOMB_B;
    end

endmodule

// File: tb/tb_bomb_engine.sv
// Self-checking bench for bomb_engine: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_bomb_engine;

    localparam int FUSE  = 3;
    localparam int HINIT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       bomb_tick, place_valid, place_player;
    logic [3:0] place_x, place_y;
    logic [3:0] playerAx, playerAy, playerBx, playerBy;
    logic [3:0] rd_x, rd_y;
    logic       place_ack;
    logic [1:0] rd_cell, healthA, healthB, game_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bomb_engine #(.FUSE_TICKS(FUSE), .HEALTH_INIT(HINIT)) dut (
        .clk(clk), .rst(rst), .bomb_tick(bomb_tick), .place_valid(place_valid),
        .place_player(place_player), .place_x(place_x), .place_y(place_y),
        .playerAx(playerAx), .playerAy(playerAy), .playerBx(playerBx), .playerBy(playerBy),
        .rd_x(rd_x), .rd_y(rd_y), .place_ack(place_ack), .rd_cell(rd_cell),
        .healthA(healthA), .healthB(healthB), .game_state(game_state)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Slot phase: 0 empty, 1 armed (ticks left in mLeft), 2 exploding.
    int mPhase[2], mX[2], mY[2], mLeft[2];
    int mHA, mHB, mGame, mAck;

    function automatic bit fp(int bx, int by, int cx, int cy);
        int dx, dy;
        if (cx < 1 || cx > 8 || cy < 1 || cy > 8) return 1'b0;
        dx = (bx > cx) ? bx - cx : cx - bx;
        dy = (by > cy) ? by - cy : cy - by;
        return (dx + dy) <= 1;
    endfunction

    function automatic int mRd(int qx, int qy);
        for (int s = 0; s < 2; s++)
            if (mPhase[s] == 2 && fp(mX[s], mY[s], qx, qy)) return 3;
        for (int s = 0; s < 2; s++)
            if (mPhase[s] == 1 && mX[s] == qx && mY[s] == qy) return s + 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mPhase[s] = 0; mX[s] = 0; mY[s] = 0; mLeft[s] = 0;
        end
        mHA = HINIT; mHB = HINIT; mGame = 0; mAck = 0;
    endtask

    task automatic model_step();
        int pp, o, px, py, g;
        bit acc, hA, hB;
        pp = int'(place_player); o = 1 - pp;
        px = int'(place_x); py = int'(place_y);
        acc = (mGame == 0) && place_valid && (mPhase[pp] == 0) &&
              px >= 1 && px <= 8 && py >= 1 && py <= 8 &&
              !(mPhase[o] == 1 && mX[o] == px && mY[o] == py);
        hA = 1'b0; hB = 1'b0;
        if (mGame == 0 && bomb_tick) begin
            for (int s = 0; s < 2; s++) begin
                if (mPhase[s] == 1) begin
                    mLeft[s] = mLeft[s] - 1;
                    if (mLeft[s] == 0) begin
                        mPhase[s] = 2;
                        if (fp(mX[s], mY[s], int'(playerAx), int'(playerAy))) hA = 1'b1;
                        if (fp(mX[s], mY[s], int'(playerBx), int'(playerBy))) hB = 1'b1;
                    end
                end else if (mPhase[s] == 2) begin
                    mPhase[s] = 0;
                end
            end
        end
        if (acc) begin
            mPhase[pp] = 1; mLeft[pp] = FUSE; mX[pp] = px; mY[pp] = py;
        end
        g = mGame;
        if (g == 0) begin
            if (mHA == 0 && mHB == 0) g = 3;
            else if (mHB == 0)        g = 1;
            else if (mHA == 0)        g = 2;
        end
        if (hA && mHA > 0) mHA--;
        if (hB && mHB > 0) mHB--;
        mGame = g;
        mAck  = acc ? 1 : 0;
    endtask

    task automatic check_model();
        chk("rnd_ack", place_ack, mAck);
        chk("rnd_healthA", healthA, mHA);
        chk("rnd_healthB", healthB, mHB);
        chk("rnd_game", game_state, mGame);
        chk("rnd_rd", rd_cell, mRd(int'(rd_x), int'(rd_y)));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_players(input int ax, input int ay, input int bx, input int by);
        playerAx = 4'(ax); playerAy = 4'(ay); playerBx = 4'(bx); playerBy = 4'(by);
    endtask

    task automatic cycle(input bit t, input bit pv, input bit pp,
                         input int px, input int py, input int rx, input int ry);
        bomb_tick = t; place_valid = pv; place_player = pp;
        place_x = 4'(px); place_y = 4'(py); rd_x = 4'(rx); rd_y = 4'(ry);
        @(posedge clk);
        model_step();
        #1;
        bomb_tick = 1'b0; place_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; bomb_tick = 1'b0; place_valid = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic query(input string name, input int qx, input int qy, input int exp);
        rd_x = 4'(qx); rd_y = 4'(qy);
        #1;
        chk(name, rd_cell, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit t; bit pv; bit pp;
        int px; int py; int rx; int ry;
        int eAck; int eRd; int eHA; int eHB; int eGame;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(bit t, bit pv, bit pp, int px, int py, int rx, int ry,
                                int eAck, int eRd, int eHA, int eHB, int eGame);
        vec_t v;
        v.t = t; v.pv = pv; v.pp = pp; v.px = px; v.py = py; v.rx = rx; v.ry = ry;
        v.eAck = eAck; v.eRd = eRd; v.eHA = eHA; v.eHB = eHB; v.eGame = eGame;
        return v;
    endfunction

    initial begin
        int cnt;
        rst = 1'b1; bomb_tick = 0; place_valid = 0; place_player = 0;
        place_x = 0; place_y = 0; rd_x = 0; rd_y = 0;
        set_players(6, 6, 3, 4);
        #12;
        chk("reset_ack", place_ack, 0);
        chk("reset_healthA", healthA, HINIT);
        chk("reset_healthB", healthB, HINIT);
        chk("reset_game", game_state, 0);
        do_reset();

        // A bombs (3,3) twice; B stands at (3,4) inside the footprint.
        vecs[0]  = mk(0, 1, 0, 3, 3, 3, 3, 1, 1, 3, 3, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 3, 3, 0, 1, 3, 3, 0);
        vecs[2]  = mk(1, 0, 0, 0, 0, 3, 3, 0, 1, 3, 3, 0);
        vecs[3]  = mk(1, 0, 0, 0, 0, 3, 3, 0, 1, 3, 3, 0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 3, 3, 0, 3, 3, 2, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 3, 4, 0, 3, 3, 2, 0);
        vecs[6]  = mk(1, 0, 0, 0, 0, 3, 3, 0, 0, 3, 2, 0);
        vecs[7]  = mk(0, 1, 0, 3, 3, 3, 3, 1, 1, 3, 2, 0);
        vecs[8]  = mk(1, 0, 0, 0, 0, 3, 3, 0, 1, 3, 2, 0);
        vecs[9]  = mk(1, 0, 0, 0, 0, 3, 3, 0, 1, 3, 2, 0);
        vecs[10] = mk(1, 0, 0, 0, 0, 3, 4, 0, 3, 3, 1, 0);
        vecs[11] = mk(1, 0, 0, 0, 0, 3, 3, 0, 0, 3, 1, 0);
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].t, vecs[i].pv, vecs[i].pp, vecs[i].px, vecs[i].py, vecs[i].rx, vecs[i].ry);
            chk($sformatf("vec%0d_ack", i), place_ack, vecs[i].eAck);
            chk($sformatf("vec%0d_rd", i), rd_cell, vecs[i].eRd);
            chk($sformatf("vec%0d_healthA", i), healthA, vecs[i].eHA);
            chk($sformatf("vec%0d_healthB", i), healthB, vecs[i].eHB);
            chk($sformatf("vec%0d_game", i), game_state, vecs[i].eGame);
        end

        // Corner bomb: wall cells are excluded from the footprint.
        do_reset();
        set_players(6, 6, 6, 7);
        cycle(0, 1, 0, 1, 1, 1, 1);
        chk("corner_ack", place_ack, 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 1, 1);
        query("corner_centre", 1, 1, 3);
        query("corner_wall_x", 0, 1, 0);
        query("corner_wall_y", 1, 0, 0);
        query("corner_right", 2, 1, 3);
        query("corner_up", 1, 2, 3);
        query("corner_diag", 2, 2, 0);

        // Rejected placements leave state untouched.
        do_reset();
        set_players(6, 6, 7, 7);
        cycle(0, 1, 0, 5, 5, 5, 5);
        chk("rej_first_ack", place_ack, 1);
        cycle(0, 1, 0, 2, 2, 2, 2);
        chk("rej_twice_ack", place_ack, 0);
        chk("rej_twice_rd", rd_cell, 0);
        cycle(0, 1, 1, 5, 5, 5, 5);
        chk("rej_onarmed_ack", place_ack, 0);
        chk("rej_onarmed_rd", rd_cell, 1);
        cycle(0, 1, 1, 0, 5, 0, 5);
        chk("rej_wall_ack", place_ack, 0);
        query("rej_wall_rd", 0, 5, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 5, 5);
        chk("rej_blast_rd", rd_cell, 3);
        cycle(1, 1, 0, 2, 2, 2, 2);
        chk("rej_blastend_ack", place_ack, 0);
        chk("rej_blastend_rd", rd_cell, 0);
        query("rej_blastend_old", 5, 5, 0);
        chk("rej_healthA", healthA, 3);
        chk("rej_healthB", healthB, 3);

        // Simultaneous double blast down to a draw, then frozen.
        do_reset();
        set_players(4, 4, 4, 5);
        for (int r = 0; r < 3; r++) begin
            cycle(0, 1, 0, 4, 4, 4, 4);
            chk($sformatf("draw_r%0d_ackA", r), place_ack, 1);
            cycle(0, 1, 1, 5, 5, 5, 5);
            chk($sformatf("draw_r%0d_ackB", r), place_ack, 1);
            for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 4, 4);
            chk($sformatf("draw_r%0d_rd", r), rd_cell, 3);
            chk($sformatf("draw_r%0d_healthA", r), healthA, 2 - r);
            chk($sformatf("draw_r%0d_healthB", r), healthB, 2 - r);
            chk($sformatf("draw_r%0d_game_lag", r), game_state, 0);
            if (r < 2) cycle(1, 0, 0, 0, 0, 4, 4);
        end
        cycle(0, 0, 0, 0, 0, 4, 4);
        chk("draw_game", game_state, 3);
        cycle(1, 0, 0, 0, 0, 4, 4);
        cycle(1, 1, 1, 7, 7, 4, 4);
        chk("draw_frozen_rd", rd_cell, 3);
        chk("draw_frozen_ack", place_ack, 0);
        chk("draw_frozen_hA", healthA, 0);
        chk("draw_frozen_game", game_state, 3);

        // Reset mid-fuse discards the bomb.
        do_reset();
        set_players(6, 6, 3, 4);
        cycle(0, 1, 0, 3, 3, 3, 3);
        cycle(1, 0, 0, 0, 0, 3, 3);
        cycle(1, 0, 0, 0, 0, 3, 3);
        chk("midrst_armed_rd", rd_cell, 1);
        rst = 1'b1;
        model_reset();
        #1;
        cnt = 0;
        for (int qx = 0; qx < 10; qx++)
            for (int qy = 0; qy < 10; qy++) begin
                rd_x = 4'(qx); rd_y = 4'(qy);
                #1;
                if (rd_cell != 2'd0) cnt++;
            end
        chk("midrst_rd_all", cnt, 0);
        chk("midrst_healthA", healthA, 3);
        chk("midrst_healthB", healthB, 3);
        chk("midrst_game", game_state, 0);
        chk("midrst_ack", place_ack, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1, 0, 0, 0, 0, 3, 3);
        chk("midrst_tick_rd", rd_cell, 0);
        query("midrst_tick_nb", 3, 4, 0);
        chk("midrst_tick_hB", healthB, 3);

        // Randomized run against the model.
        do_reset();
        for (int it = 0; it < 4000; it++) begin
            bit t, pv, pp;
            int px, py;
            if (it % 250 == 249) do_reset();
            if ($urandom_range(0, 7) == 0)
                set_players($urandom_range(0, 9), $urandom_range(1, 8),
                            $urandom_range(1, 8), $urandom_range(0, 9));
            t  = ($urandom_range(0, 2) == 0);
            pv = ($urandom_range(0, 2) == 0);
            pp = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0: begin px = int'(playerAx) + $urandom_range(0, 1); py = int'(playerAy); end
                1: begin px = int'(playerBx); py = int'(playerBy) - $urandom_range(0, 1); end
                default: begin px = $urandom_range(0, 9); py = $urandom_range(0, 9); end
            endcase
            cycle(t, pv, pp, px, py, $urandom_range(0, 9), $urandom_range(0, 9));
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
